// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and sequencer that shares the 256x8 data memory between
// the CPU datapath (port 0) and the debug/DMA loader (port 1).
module data_mem_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rvalid0,
  output logic       rvalid1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic [7:0] mem_address,
  output logic       mem_write,
  output logic       mem_read,
  output logic [7:0] mem_write_data,
  input  logic [7:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t     state;
  logic       last;
  logic       owner;
  logic       owner_we;
  logic       pick;
  logic       pick_we;
  logic [7:0] pick_addr;
  logic [7:0] pick_wdata;

  // On a tie the port that was not granted most recently wins.
  always_comb begin
    pick       = (req0 && req1) ? ~last : req1;
    pick_we    = pick ? we1 : we0;
    pick_addr  = pick ? addr1 : addr0;
    pick_wdata = pick ? wdata1 : wdata0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      last           <= 1'b1;
      owner          <= 1'b0;
      owner_we       <= 1'b0;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      rvalid0        <= 1'b0;
      rvalid1        <= 1'b0;
      rdata0         <= 8'h00;
      rdata1         <= 8'h00;
      mem_address    <= 8'h00;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
      mem_write_data <= 8'h00;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner          <= pick;
            owner_we       <= pick_we;
            mem_address    <= pick_addr;
            mem_write_data <= pick_wdata;
            mem_write      <= pick_we;
            mem_read       <= ~pick_we;
            gnt0           <= ~pick;
            gnt1           <= pick;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          last  <= owner;
          state <= owner_we ? IDLE : WAIT;
        end
        WAIT: begin
          // Read data goes to the registered owner, whatever the req lines show now.
          if (owner) begin
            rdata1  <= mem_read_data;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= mem_read_data;
            rvalid0 <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
